// File: rtl/pipe_scheduler.sv
// pipe_scheduler: owns NUM_PIPES pipe slots, moves/spawns them per tick, streams active pipes to the renderer; PIPE_SCHED_OVERRUN_EN enables the dropped-tick counter
module pipe_scheduler #(
  parameter int         NUM_PIPES  = 3,
  parameter logic [7:0] SPAWN_X    = 8'd160,
  parameter logic [7:0] SPACING    = 8'd40,
  parameter logic [6:0] DEFAULT_Y  = 7'd50,
  parameter logic [6:0] GAP_MAX    = 7'd100,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       tick,
  input  logic       run,
  input  logic [6:0] y_in,
  input  logic       y_valid,
  output logic       y_ready,
  output logic       draw_valid,
  input  logic       draw_ready,
  output logic [1:0] draw_slot,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       frame_done,
  output logic [3:0] active_mask,
  output logic [7:0] overrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, MOVE, SPAWN, DRAW, DONE} state_t;
  state_t state;
  logic [NUM_PIPES-1:0] active;
  logic [7:0] slot_x [NUM_PIPES];
  logic [6:0] slot_y [NUM_PIPES];
  logic [6:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [7:0] spawn_cnt;
  logic [1:0] idx, nxt, free_idx;
  logic has_free, push, pop, do_spawn, hit0, last;
  logic [6:0] spawn_y;
  assign y_ready     = count != (AW+1)'(FIFO_DEPTH);
  assign push        = y_valid && y_ready;
  assign do_spawn    = state == SPAWN && spawn_cnt == SPACING - 8'd1 && has_free;
  assign pop         = do_spawn && count != '0;
  assign spawn_y     = count != '0 ? fifo[rd_ptr] : DEFAULT_Y;
  assign hit0        = do_spawn && free_idx == 2'd0;
  assign nxt         = idx + 2'd1;
  assign last        = idx == 2'(NUM_PIPES - 1);
  assign active_mask = 4'(active);
  // lowest-index free slot, seen after the MOVE retirements have landed
  always_comb begin
    free_idx = '0;
    has_free = 1'b0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      free_idx = !active[i] ? 2'(i) : free_idx;
      has_free = has_free | !active[i];
    end
  end
  // gap FIFO storage, clamped on entry
  always_ff @(posedge CLOCK_50)
    if (push) fifo[wr_ptr] <= y_in > GAP_MAX ? GAP_MAX : y_in;
  // gap FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // tick sequencer: move, spawn, then stream active slots with registered draw outputs
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      active     <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
      spawn_cnt  <= SPACING - 8'd1;
      idx        <= '0;
      draw_valid <= 1'b0;
      draw_slot  <= '0;
      draw_x     <= '0;
      draw_y     <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick && run) state <= MOVE;
        MOVE: begin
          for (int i = 0; i < NUM_PIPES; i++)
            if (active[i]) begin
              if (slot_x[i] == '0) active[i] <= 1'b0;
              else slot_x[i] <= slot_x[i] - 8'd1;
            end
          state <= SPAWN;
        end
        SPAWN: begin
          if (do_spawn) begin
            active[free_idx] <= 1'b1;
            slot_x[free_idx] <= SPAWN_X;
            slot_y[free_idx] <= spawn_y;
            spawn_cnt        <= '0;
          end else if (spawn_cnt != SPACING - 8'd1) spawn_cnt <= spawn_cnt + 8'd1;
          idx        <= '0;
          draw_slot  <= '0;
          draw_valid <= active[0] | hit0;
          draw_x     <= hit0 ? SPAWN_X : slot_x[0];
          draw_y     <= hit0 ? spawn_y : slot_y[0];
          state      <= DRAW;
        end
        DRAW: if (!draw_valid || draw_ready) begin
          if (last) begin
            draw_valid <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx        <= nxt;
            draw_slot  <= nxt;
            draw_valid <= active[nxt];
            draw_x     <= slot_x[nxt];
            draw_y     <= slot_y[nxt];
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PIPE_SCHED_OVERRUN_EN
  // saturating count of run ticks that arrive while a sequence is in flight
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) overrun_count <= '0;
    else if (state != IDLE && tick && run && overrun_count != 8'hff) overrun_count <= overrun_count + 8'd1;
  end
`else
  assign overrun_count = 8'd0;
`endif
endmodule
